// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between the fetch (I) and memory (D) stages.
// Optional MEM_ARBITER_PERF_EN adds wrapping grant/conflict/kill performance counters.
module mem_arbiter #(
   parameter int unsigned AW           = 32,
   parameter int unsigned DW           = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   input  logic            i_kill,
   output logic [DW-1:0]   i_rdata,
   output logic            i_ready,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_be,
   output logic [DW-1:0]   d_rdata,
   output logic            d_ready,
   output logic            mem_req,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_be,
   input  logic [DW-1:0]   mem_rdata,
   input  logic            mem_ready,
   output logic            stall_f,
   output logic            stall_m
`ifdef MEM_ARBITER_PERF_EN
   ,
   output logic [31:0]     perf_i_grants,
   output logic [31:0]     perf_d_grants,
   output logic [31:0]     perf_conflicts,
   output logic [31:0]     perf_killed
`endif
);

   localparam int unsigned BW        = DW / 8;
   localparam logic [3:0]  StarveMax = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

   state_e           state_q, state_d;
   logic             killed_q, killed_d;
   logic [3:0]       starve_cnt_q, starve_cnt_d;
   logic             mem_we_q, mem_we_d;
   logic [AW-1:0]    mem_addr_q, mem_addr_d;
   logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
   logic [BW-1:0]    mem_be_q, mem_be_d;
   logic             grant_i, grant_d, kill_done;

   always_comb begin
      state_d      = state_q;
      killed_d     = killed_q;
      starve_cnt_d = starve_cnt_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_be_d     = mem_be_q;
      grant_i      = 1'b0;
      grant_d      = 1'b0;
      kill_done    = 1'b0;
      i_ready      = 1'b0;
      d_ready      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (i_req && !i_kill && (!d_req || starve_cnt_q == StarveMax)) begin
               grant_i     = 1'b1;
               state_d     = StBusyI;
               mem_we_d    = 1'b0;
               mem_addr_d  = i_addr;
               mem_wdata_d = '0;
               mem_be_d    = '1;
            end else if (d_req) begin
               grant_d     = 1'b1;
               state_d     = StBusyD;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               mem_be_d    = d_be;
            end
         end
         StBusyI: begin
            if (mem_ready) begin
               // A kill landing in the completion cycle also swallows the response.
               kill_done = killed_q | i_kill;
               i_ready   = ~kill_done;
               killed_d  = 1'b0;
               state_d   = StIdle;
            end else if (i_kill) begin
               killed_d = 1'b1;
            end
         end
         StBusyD: begin
            if (mem_ready) begin
               d_ready = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (grant_i || !i_req) begin
         starve_cnt_d = '0;
      end else if (grant_d && !i_kill && starve_cnt_q != StarveMax) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         killed_q     <= 1'b0;
         starve_cnt_q <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_be_q     <= '0;
      end else begin
         state_q      <= state_d;
         killed_q     <= killed_d;
         starve_cnt_q <= starve_cnt_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_be_q     <= mem_be_d;
      end
   end

   assign mem_req   = (state_q != StIdle);
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign i_rdata   = mem_rdata;
   assign d_rdata   = mem_rdata;
   assign stall_f   = i_req & ~i_ready;
   assign stall_m   = d_req & ~d_ready;

`ifdef MEM_ARBITER_PERF_EN
   logic [31:0] perf_i_grants_q, perf_i_grants_d;
   logic [31:0] perf_d_grants_q, perf_d_grants_d;
   logic [31:0] perf_conflicts_q, perf_conflicts_d;
   logic [31:0] perf_killed_q, perf_killed_d;

   always_comb begin
      perf_i_grants_d  = perf_i_grants_q + {31'd0, grant_i};
      perf_d_grants_d  = perf_d_grants_q + {31'd0, grant_d};
      perf_conflicts_d = perf_conflicts_q + {31'd0, (state_q == StIdle) & i_req & d_req};
      perf_killed_d    = perf_killed_q + {31'd0, kill_done};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         perf_i_grants_q  <= '0;
         perf_d_grants_q  <= '0;
         perf_conflicts_q <= '0;
         perf_killed_q    <= '0;
      end else begin
         perf_i_grants_q  <= perf_i_grants_d;
         perf_d_grants_q  <= perf_d_grants_d;
         perf_conflicts_q <= perf_conflicts_d;
         perf_killed_q    <= perf_killed_d;
      end
   end

   assign perf_i_grants  = perf_i_grants_q;
   assign perf_d_grants  = perf_d_grants_q;
   assign perf_conflicts = perf_conflicts_q;
   assign perf_killed    = perf_killed_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table of single transactions plus
// hand-written reset, starvation and kill sequences against a latency-programmable memory.
module tb_mem_arbiter;

   logic        clk;
   logic        reset_n;
   logic        i_req, i_kill, i_ready;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_ready;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_be, mem_be;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        stall_f, stall_m;
`ifdef MEM_ARBITER_PERF_EN
   logic [31:0] perf_i_grants, perf_d_grants, perf_conflicts, perf_killed;
`endif

   int          errors = 0;
   int          checks = 0;
   int unsigned mem_lat = 0;
   int unsigned lat_cnt = 0;
   logic [31:0] mem_rdata_v = '0;

   mem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_kill    (i_kill),
      .i_rdata   (i_rdata),
      .i_ready   (i_ready),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_be      (d_be),
      .d_rdata   (d_rdata),
      .d_ready   (d_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .stall_f   (stall_f),
      .stall_m   (stall_m)
`ifdef MEM_ARBITER_PERF_EN
      ,
      .perf_i_grants  (perf_i_grants),
      .perf_d_grants  (perf_d_grants),
      .perf_conflicts (perf_conflicts),
      .perf_killed    (perf_killed)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory answers mem_lat cycles after the first mem_req cycle of a transaction.
   always @(posedge clk) begin
      if (!mem_req || mem_ready) lat_cnt <= 0;
      else lat_cnt <= lat_cnt + 1;
   end
   assign mem_ready = mem_req && (lat_cnt == mem_lat);
   assign mem_rdata = mem_rdata_v;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required to finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (mem_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (mem_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   typedef struct {
      logic        i_req;
      logic        i_kill;
      logic [31:0] i_addr;
      logic        d_req;
      logic        d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic [3:0]  d_be;
      int unsigned lat;
      logic [31:0] rdata;
      logic [31:0] exp_addr;
      logic        exp_we;
      logic [3:0]  exp_be;
      logic        exp_i_ready;
      logic        exp_d_ready;
      logic        exp_stall_f;
      logic        exp_stall_m;
   } vec_t;

   vec_t vecs[5];

   initial begin
      bit          ok;
      bit          seen;
      bit          prev;
      bit          is_i[$];
      logic [31:0] perf_before;

      vecs[0] = '{1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 3, 32'hDEADBEEF,
                  32'h100, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 32'h12345678, 4'h3, 1, 32'h0,
                  32'h200, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h204, 32'h0,        4'hF, 0, 32'hA5A50001,
                  32'h204, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 32'h104, 1'b1, 1'b0, 32'h208, 32'h0,        4'hC, 2, 32'h0BADF00D,
                  32'h208, 1'b0, 4'hC, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 32'h108, 1'b1, 1'b1, 32'h20C, 32'hCAFEF00D, 4'hF, 1, 32'h0,
                  32'h20C, 1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0};

      // Reset held with both requesters active
      reset_n = 1'b0; i_req = 1'b1; i_kill = 1'b0; i_addr = 32'h1F0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2F0; d_wdata = '0; d_be = 4'hF;
      mem_lat = 0; mem_rdata_v = 32'h0;
      repeat (2) @(negedge clk);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_i_ready", i_ready, 1'b0);
      check("rst_d_ready", d_ready, 1'b0);
      check("rst_stall_f", stall_f, 1'b1);
      check("rst_stall_m", stall_m, 1'b1);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_first_grant_req", mem_req, 1'b1);
      check("rst_first_grant_is_d", mem_addr, 32'h2F0);
      wait_ready(ok);
      check("rst_first_ready_seen", ok, 1'b1);
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);

      // Table-driven single transactions, each starting and ending in IDLE
      for (int v = 0; v < 5; v++) begin
         i_req = vecs[v].i_req; i_kill = vecs[v].i_kill; i_addr = vecs[v].i_addr;
         d_req = vecs[v].d_req; d_we = vecs[v].d_we; d_addr = vecs[v].d_addr;
         d_wdata = vecs[v].d_wdata; d_be = vecs[v].d_be;
         mem_lat = vecs[v].lat; mem_rdata_v = vecs[v].rdata;
         @(negedge clk);
         wait_req(ok);
         check($sformatf("v%0d_grant_seen", v), ok, 1'b1);
         check($sformatf("v%0d_mem_addr", v), mem_addr, vecs[v].exp_addr);
         check($sformatf("v%0d_mem_we", v), mem_we, vecs[v].exp_we);
         check($sformatf("v%0d_mem_be", v), mem_be, vecs[v].exp_be);
         if (vecs[v].exp_we) check($sformatf("v%0d_mem_wdata", v), mem_wdata, vecs[v].d_wdata);
         wait_ready(ok);
         check($sformatf("v%0d_ready_seen", v), ok, 1'b1);
         check($sformatf("v%0d_i_ready", v), i_ready, vecs[v].exp_i_ready);
         check($sformatf("v%0d_d_ready", v), d_ready, vecs[v].exp_d_ready);
         check($sformatf("v%0d_stall_f", v), stall_f, vecs[v].exp_stall_f);
         check($sformatf("v%0d_stall_m", v), stall_m, vecs[v].exp_stall_m);
         if (vecs[v].exp_i_ready) check($sformatf("v%0d_i_rdata", v), i_rdata, vecs[v].rdata);
         if (vecs[v].exp_d_ready) check($sformatf("v%0d_d_rdata", v), d_rdata, vecs[v].rdata);
         i_req = 1'b0; i_kill = 1'b0; d_req = 1'b0;
         @(negedge clk);
         check($sformatf("v%0d_idle_after", v), mem_req, 1'b0);
      end

      // Starvation guard: continuous conflict must grant DDDDI DDDDI
      i_req = 1'b1; i_addr = 32'h180; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h280; d_be = 4'hF;
      mem_lat = 1; prev = 1'b0;
      for (int k = 0; k < 300 && is_i.size() < 10; k++) begin
         if (mem_req && !prev) is_i.push_back(mem_addr[9:8] == 2'd1);
         prev = mem_req;
         if (is_i.size() < 10) @(negedge clk);
      end
      check("starve_grant_count", is_i.size(), 10);
      for (int k = 0; k < is_i.size(); k++)
         check($sformatf("starve_grant%0d_is_i", k), is_i[k], (k == 4 || k == 9));
      d_req = 1'b0;
      wait_ready(ok);
      check("starve_last_ready_seen", ok, 1'b1);
      i_req = 1'b0;
      @(negedge clk);

      // Kill pulse while the fetch is in flight, with a load queued behind it
      i_req = 1'b1; i_addr = 32'h140; mem_lat = 3;
      @(negedge clk);
      wait_req(ok);
      check("kif_grant_seen", ok, 1'b1);
      i_kill = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h240;
      @(negedge clk);
      i_kill = 1'b0;
      seen = 1'b0; ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (i_ready) seen = 1'b1;
         if (mem_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("kif_ready_seen", ok, 1'b1);
      check("kif_mem_addr", mem_addr, 32'h140);
      check("kif_i_ready_suppressed", seen, 1'b0);
      i_req = 1'b0;
      @(negedge clk);
      check("kif_idle", mem_req, 1'b0);
      @(negedge clk);
      check("kif_d_grant_req", mem_req, 1'b1);
      check("kif_d_grant_addr", mem_addr, 32'h240);
      wait_ready(ok);
      check("kif_d_ready", d_ready, 1'b1);
      d_req = 1'b0;
      @(negedge clk);

      // Kill arriving in the same cycle as mem_ready
`ifdef MEM_ARBITER_PERF_EN
      perf_before = perf_killed;
`else
      perf_before = 32'h0;
`endif
      i_req = 1'b1; i_addr = 32'h144; mem_lat = 2;
      @(negedge clk);
      wait_req(ok);
      wait_ready(ok);
      check("kc_ready_seen", ok, 1'b1);
      i_kill = 1'b1;
      #1;
      check("kc_i_ready", i_ready, 1'b0);
      check("kc_stall_f", stall_f, 1'b1);
      @(negedge clk);
      check("kc_idle_blocked", mem_req, 1'b0);
      i_req = 1'b0; i_kill = 1'b0;
      @(negedge clk);
`ifdef MEM_ARBITER_PERF_EN
      check("kc_perf_killed", perf_killed, perf_before + 32'd1);
`endif
      check("kc_still_idle", mem_req, 1'b0);

      // Next fetch must not inherit any kill
      i_req = 1'b1; i_addr = 32'h148; mem_lat = 0; mem_rdata_v = 32'h600D600D;
      @(negedge clk);
      wait_ready(ok);
      check("post_kill_ready_seen", ok, 1'b1);
      check("post_kill_i_ready", i_ready, 1'b1);
      check("post_kill_i_rdata", i_rdata, 32'h600D600D);
      i_req = 1'b0;
      @(negedge clk);

      // Reset in the middle of a transaction abandons it
      i_req = 1'b1; i_addr = 32'h14C; mem_lat = 5;
      @(negedge clk);
      wait_req(ok);
      reset_n = 1'b0;
      @(negedge clk);
      check("mid_rst_mem_req", mem_req, 1'b0);
      check("mid_rst_i_ready", i_ready, 1'b0);
      check("mid_rst_mem_addr", mem_addr, 32'h0);
      reset_n = 1'b1; i_req = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
